// File: rtl/mflushpwr_flush_ctrl_if.sv
// ---------------------------------------------------------------------------
// mflushpwr_flush_ctrl_if
// Groups the CSR, L2 flush handshake, status and difftest event signals of
// the mflushpwr flush controller.
//   master modport : core/CSR/L2 side, drives the inputs of the controller
//   slave modport  : the controller itself
// Signals:
//   io_csr_wen, io_csr_wdata[1:0]   CSR write strobe / data (bit0 start, bit1 clear)
//   io_l2_flush_ack, io_l2_flush_done  L2 handshake inputs
//   io_hartid[7:0]                  core id, sampled at start
//   io_l2_flush_req                 flush request to L2
//   io_busy, io_l2FlushDone, io_timeout  status
//   io_diff_valid, io_diff_l2FlushDone, io_diff_coreid[7:0]  difftest event
// ---------------------------------------------------------------------------
interface mflushpwr_flush_ctrl_if;
    logic       io_csr_wen;
    logic [1:0] io_csr_wdata;
    logic       io_l2_flush_ack;
    logic       io_l2_flush_done;
    logic [7:0] io_hartid;
    logic       io_l2_flush_req;
    logic       io_busy;
    logic       io_l2FlushDone;
    logic       io_timeout;
    logic       io_diff_valid;
    logic       io_diff_l2FlushDone;
    logic [7:0] io_diff_coreid;

    modport master (
        output io_csr_wen, io_csr_wdata, io_l2_flush_ack, io_l2_flush_done, io_hartid,
        input  io_l2_flush_req, io_busy, io_l2FlushDone, io_timeout,
        input  io_diff_valid, io_diff_l2FlushDone, io_diff_coreid
    );

    modport slave (
        input  io_csr_wen, io_csr_wdata, io_l2_flush_ack, io_l2_flush_done, io_hartid,
        output io_l2_flush_req, io_busy, io_l2FlushDone, io_timeout,
        output io_diff_valid, io_diff_l2FlushDone, io_diff_coreid
    );
endinterface

// File: rtl/mflushpwr_flush_ctrl.sv
// ---------------------------------------------------------------------------
// mflushpwr_flush_ctrl
// Core-side initiator of the mflushpwr sequence: a CSR start write raises an
// L2 flush request (held until ack), then waits for flush completion bounded
// by a timeout, updates the sticky status bits and emits a one-cycle
// difftest event record.
// Ports:
//   clock    core clock
//   reset_n  synchronous active-low reset
//   bus      mflushpwr_flush_ctrl_if.slave (CSR, L2 handshake, status, event)
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles before abort (>= 2)
//   CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
// Configuration macro:
//   MFLUSHPWR_DIFFTEST_EN  defined   -> io_diff_* carry the event record
//                          undefined -> io_diff_* tied to 0
// ---------------------------------------------------------------------------
module mflushpwr_flush_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic                         clock,
    input  logic                         reset_n,
    mflushpwr_flush_ctrl_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_flag_q, done_flag_d;
    logic               req_q, req_d;
    logic               busy_q;
    logic               l2done_q, l2done_d;
    logic               timeout_q, timeout_d;
    logic               start_s;
    logic               clear_s;

    assign start_s = bus.io_csr_wen & bus.io_csr_wdata[0];
    assign clear_s = bus.io_csr_wen & bus.io_csr_wdata[1];

    // Next-state and next-output logic of the flush sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_flag_d = done_flag_q;
        req_d       = 1'b0;
        l2done_d    = l2done_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE: begin
                // start wins over clear, but a start clears the sticky bits anyway
                if (start_s) begin
                    state_d   = ST_REQ;
                    req_d     = 1'b1;
                    l2done_d  = 1'b0;
                    timeout_d = 1'b0;
                end else if (clear_s) begin
                    l2done_d  = 1'b0;
                    timeout_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_REQ: begin
                // request is held until the cycle after ack; no timeout here
                if (bus.io_l2_flush_ack) begin
                    state_d = ST_WAIT;
                    cnt_d   = {CNT_W{1'b0}};
                    req_d   = 1'b0;
                end else begin
                    req_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                // done has priority over the final timeout count
                if (bus.io_l2_flush_done) begin
                    state_d     = ST_REPORT;
                    done_flag_d = 1'b1;
                end else if (cnt_q == LAST_CNT) begin
                    state_d     = ST_REPORT;
                    done_flag_d = 1'b0;
                    timeout_d   = 1'b1;
                end else if (cnt_q != MAX_CNT) begin
                    cnt_d       = cnt_q + CNT_W'(1'b1);
                end else begin
                    cnt_d       = cnt_q;
                end
            end
            ST_REPORT: begin
                l2done_d = done_flag_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered status outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            done_flag_q <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            l2done_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_flag_q <= done_flag_d;
            req_q       <= req_d;
            busy_q      <= (state_d != ST_IDLE);
            l2done_q    <= l2done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.io_l2_flush_req = req_q;
    assign bus.io_busy         = busy_q;
    assign bus.io_l2FlushDone  = l2done_q;
    assign bus.io_timeout      = timeout_q;

`ifdef MFLUSHPWR_DIFFTEST_EN
    logic [7:0] coreid_q, coreid_d;
    logic       diff_valid_q;
    logic       diff_done_q;
    logic [7:0] diff_coreid_q;
    logic       report_next_s;

    assign report_next_s = (state_d == ST_REPORT);

    // Capture the hart id when a sequence is accepted
    always_comb begin
        coreid_d = coreid_q;
        if ((state_q == ST_IDLE) && start_s) begin
            coreid_d = bus.io_hartid;
        end else begin
            coreid_d = coreid_q;
        end
    end

    // Event record registered so it is valid exactly during REPORT
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            coreid_q      <= 8'h00;
            diff_valid_q  <= 1'b0;
            diff_done_q   <= 1'b0;
            diff_coreid_q <= 8'h00;
        end else begin
            coreid_q      <= coreid_d;
            diff_valid_q  <= report_next_s;
            diff_done_q   <= report_next_s & done_flag_d;
            diff_coreid_q <= report_next_s ? coreid_d : 8'h00;
        end
    end

    assign bus.io_diff_valid       = diff_valid_q;
    assign bus.io_diff_l2FlushDone = diff_done_q;
    assign bus.io_diff_coreid      = diff_coreid_q;
`else
    assign bus.io_diff_valid       = 1'b0;
    assign bus.io_diff_l2FlushDone = 1'b0;
    assign bus.io_diff_coreid      = 8'h00;
`endif

endmodule
